seg7_mux_scroll: RTL and testbench

SEG7_MUX_SCROLL -- requirements
Module: seg7_mux_scroll

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/tick_gen.sv | 31 +++
 rtl/seg7_mux_scroll.sv | 136 +++++++++++++
 tb/tb_seg7_mux_scroll.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// segment encoding, the blank pattern and the display mode.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SCROLL = 1'b1
    } mode_e;

    // Segment pattern ordered {g,f,e,d,c,b,a}, a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divider producing a one-cycle tick every DIV enabled clocks.
// Dropping en clears the count, so the first tick after re-enabling
// arrives a full DIV clocks later.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk_100Mhz,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CNT_LAST);

    // Count 0..DIV-1, restart on terminal count or while disabled.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_mux_scroll.sv
// Time-multiplexed seven-segment driver with static display (optional
// leading-zero suppression) and a right-to-left scrolling message mode.
module seg7_mux_scroll
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 12500,
    parameter int SCROLL_DIV  = 25_000_000
) (
    input  logic                  clk_100Mhz_pi,
    input  logic                  reset_n_pi,
    input  logic [4*N_DIGITS-1:0] data_pi,
    input  logic                  load_pi,
    input  logic                  mode_pi,
    input  logic                  lz_en_pi,
    input  logic [N_DIGITS-1:0]   blank_pi,
    input  logic [N_DIGITS-1:0]   dp_pi,
    output logic [6:0]            display_po,
    output logic                  dp_po,
    output logic [N_DIGITS-1:0]   display_select_po,
    output logic                  scroll_wrap_po
);

    localparam int IW = $clog2(N_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] msg_q;
    logic [4*N_DIGITS-1:0] win_q;
    logic [N_DIGITS-1:0]   win_blank_q;
    mode_e                 mode_q;
    logic                  lz_q;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         pos_q;

    logic                  ref_tick;
    logic                  scr_tick;
    logic                  scr_en;
    logic [IW-1:0]         scr_nib_idx;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_blank;

    // A load holds the scroll divider in clear, which also swallows a
    // coincident scroll tick.
    assign scr_en      = (mode_q == MODE_SCROLL) && !load_pi;
    assign scr_nib_idx = LAST - pos_q;

    tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
        .clk_100Mhz (clk_100Mhz_pi),
        .reset_n    (reset_n_pi),
        .en         (1'b1),
        .tick       (ref_tick)
    );

    tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
        .clk_100Mhz (clk_100Mhz_pi),
        .reset_n    (reset_n_pi),
        .en         (scr_en),
        .tick       (scr_tick)
    );

    // lead_zero[k] is set when message digits k..top are all zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (msg_q[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    // Select the nibble and blanking for the digit currently being driven.
    always_comb begin
        cur_nib   = msg_q[{idx_q, 2'b00} +: 4];
        cur_blank = blank_pi[idx_q];
        if (mode_q == MODE_SCROLL) begin
            cur_nib   = win_q[{idx_q, 2'b00} +: 4];
            cur_blank = cur_blank | win_blank_q[idx_q];
        end else if (lz_q && (idx_q != '0) && lead_zero[idx_q]) begin
            cur_blank = 1'b1;
        end
    end

    // Advance the multiplexed digit index on each refresh tick.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_n_pi) begin
            idx_q <= '0;
        end else if (ref_tick) begin
            idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Register anode, cathodes and decimal point together so they switch
    // digits on the same edge.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_n_pi) begin
            display_select_po <= '1;
            display_po        <= SEG_BLANK;
            dp_po             <= 1'b1;
        end else begin
            display_select_po <= ~(N_DIGITS'(1) << idx_q);
            display_po        <= cur_blank ? SEG_BLANK : hex_to_seg(cur_nib);
            dp_po             <= cur_blank | ~dp_pi[idx_q];
        end
    end

    // Message capture and scrolling window; a load always wins over a tick.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (!reset_n_pi) begin
            msg_q          <= '0;
            mode_q         <= MODE_STATIC;
            lz_q           <= 1'b0;
            win_q          <= '0;
            win_blank_q    <= '0;
            pos_q          <= '0;
            scroll_wrap_po <= 1'b0;
        end else begin
            scroll_wrap_po <= 1'b0;
            if (load_pi) begin
                msg_q       <= data_pi;
                mode_q      <= mode_e'(mode_pi);
                lz_q        <= lz_en_pi;
                win_q       <= '0;
                win_blank_q <= mode_pi ? '1 : '0;
                pos_q       <= '0;
            end else if (scr_tick) begin
                win_q          <= {win_q[4*N_DIGITS-5:0], msg_q[{scr_nib_idx, 2'b00} +: 4]};
                win_blank_q    <= {win_blank_q[N_DIGITS-2:0], 1'b0};
                pos_q          <= (pos_q == LAST) ? '0 : pos_q + 1'b1;
                scroll_wrap_po <= (pos_q == LAST);
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_scroll.sv
// Directed bench for seg7_mux_scroll with 8 digits, refresh every 4 clocks
// and a scroll step every 64 clocks.
module tb_seg7_mux_scroll;

    localparam int N = 8;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clk_100Mhz = 1'b0;
    logic          reset_n    = 1'b0;
    logic [31:0]   data       = '0;
    logic          load       = 1'b0;
    logic          mode       = 1'b0;
    logic          lz_en      = 1'b0;
    logic [N-1:0]  blank      = '0;
    logic [N-1:0]  dp         = '0;
    logic [6:0]    display;
    logic          dp_out;
    logic [N-1:0]  sel;
    logic          wrap;

    int            cyc = 0;
    int            lc  = 0;
    int            base;
    int            n_checks = 0;
    int            n_fail   = 0;

    logic [6:0]    rd_seg [N];
    logic          rd_dp  [N];

    always #5 clk_100Mhz = ~clk_100Mhz;

    always @(posedge clk_100Mhz) cyc <= cyc + 1;

    seg7_mux_scroll #(
        .N_DIGITS    (N),
        .REFRESH_DIV (4),
        .SCROLL_DIV  (64)
    ) dut (
        .clk_100Mhz_pi     (clk_100Mhz),
        .reset_n_pi        (reset_n),
        .data_pi           (data),
        .load_pi           (load),
        .mode_pi           (mode),
        .lz_en_pi          (lz_en),
        .blank_pi          (blank),
        .dp_pi             (dp),
        .display_po        (display),
        .dp_po             (dp_out),
        .display_select_po (sel),
        .scroll_wrap_po    (wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample 40 cycles, recording what each anode showed while active.
    task automatic read_all();
        for (int k = 0; k < N; k++) begin
            rd_seg[k] = 7'h55;
            rd_dp[k]  = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_100Mhz);
            for (int k = 0; k < N; k++) begin
                if (sel == ~(8'h01 << k)) begin
                    rd_seg[k] = display;
                    rd_dp[k]  = dp_out;
                end
            end
        end
    endtask

    task automatic check_window(input string tag, input logic [31:0] val, input logic [N-1:0] bmask);
        logic [6:0] exp_seg;
        read_all();
        for (int k = 0; k < N; k++) begin
            exp_seg = bmask[k] ? 7'h7F : SEG[val[4*k +: 4]];
            check($sformatf("%s_d%0d", tag, k), {25'd0, rd_seg[k]}, {25'd0, exp_seg});
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic m, input logic lz);
        @(negedge clk_100Mhz);
        data  = d;
        mode  = m;
        lz_en = lz;
        load  = 1'b1;
        @(posedge clk_100Mhz);
        #1 lc = cyc;
        @(negedge clk_100Mhz);
        load = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 100000 && cyc < t; i++) @(negedge clk_100Mhz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk_100Mhz);
        check("rst_sel", {24'd0, sel}, 32'hFF);
        check("rst_seg", {25'd0, display}, 32'h7F);
        check("rst_dp", {31'd0, dp_out}, 32'h1);
        check("rst_wrap", {31'd0, wrap}, 32'h0);
        reset_n = 1'b1;

        // Anode rotation with no load: 4 clocks per digit, all zeros shown
        for (int i = 0; i < 40 && sel !== 8'hFE; i++) @(negedge clk_100Mhz);
        for (int k = 0; k < N; k++) begin
            check($sformatf("cyc_sel%0d", k), {24'd0, sel}, {24'd0, ~(8'h01 << k)});
            check($sformatf("cyc_seg%0d", k), {25'd0, display}, {25'd0, SEG[0]});
            repeat (4) @(negedge clk_100Mhz);
        end
        check("cyc_sel_wrap", {24'd0, sel}, 32'hFE);

        // Static message
        do_load(32'h89AB_CDEF, 1'b0, 1'b0);
        check_window("st", 32'h89AB_CDEF, 8'h00);

        // Leading-zero suppression
        do_load(32'h0000_0A50, 1'b0, 1'b1);
        check_window("lz", 32'h0000_0A50, 8'hF8);
        do_load(32'h0000_0000, 1'b0, 1'b1);
        check_window("lz0", 32'h0000_0000, 8'hFE);

        // Live blank and decimal point
        do_load(32'h89AB_CDEF, 1'b0, 1'b0);
        @(negedge clk_100Mhz);
        blank = 8'h01;
        dp    = 8'h03;
        read_all();
        check("bl_seg0", {25'd0, rd_seg[0]}, 32'h7F);
        check("bl_dp0", {31'd0, rd_dp[0]}, 32'h1);
        check("dp_seg1", {25'd0, rd_seg[1]}, {25'd0, SEG[14]});
        check("dp_dp1", {31'd0, rd_dp[1]}, 32'h0);
        check("dp_dp2", {31'd0, rd_dp[2]}, 32'h1);
        blank = '0;
        dp    = '0;

        // Scrolling
        do_load(32'hDA1E_BEBE, 1'b1, 1'b0);
        wait_cyc(lc + 64);
        check("wrap_t1", {31'd0, wrap}, 32'h0);
        wait_cyc(lc + 66);
        check_window("t1", 32'h0000_000D, 8'hFE);
        wait_cyc(lc + 194);
        check_window("t3", 32'h0000_0DA1, 8'hF8);
        wait_cyc(lc + 512);
        check("wrap_t8", {31'd0, wrap}, 32'h1);
        @(negedge clk_100Mhz);
        check("wrap_t8_end", {31'd0, wrap}, 32'h0);
        check_window("t8", 32'hDA1E_BEBE, 8'h00);
        wait_cyc(lc + 578);
        check_window("t9", 32'hA1EB_EBED, 8'h00);

        // Reset in the middle of scroll step 5
        do_load(32'hDA1E_BEBE, 1'b1, 1'b0);
        wait_cyc(lc + 64 * 4 + 30);
        @(negedge clk_100Mhz);
        reset_n = 1'b0;
        @(negedge clk_100Mhz);
        check("mrst_sel", {24'd0, sel}, 32'hFF);
        check("mrst_seg", {25'd0, display}, 32'h7F);
        check("mrst_dp", {31'd0, dp_out}, 32'h1);
        check("mrst_wrap", {31'd0, wrap}, 32'h0);
        reset_n = 1'b1;
        check_window("mrst_a", 32'h0, 8'h00);
        repeat (64) @(negedge clk_100Mhz);
        check_window("mrst_b", 32'h0, 8'h00);

        // Load coincident with the third scroll tick
        do_load(32'h1234_5678, 1'b1, 1'b0);
        base = lc;
        wait_cyc(base + 190);
        do_load(32'h1234_5678, 1'b1, 1'b0);
        check("ldtick_edge", lc, base + 192);
        check_window("ldtick_clr", 32'h0, 8'hFF);
        wait_cyc(lc + 66);
        check_window("ldtick_t1", 32'h0000_0001, 8'hFE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
